options_parser_stream: RTL and testbench
========================================

OPTIONS_PARSER_STREAM -- requirements
Module: options_parser_stream

Interface
REQ-001 SHALL have parameter W, default 32: option word width in bits.
REQ-002 SHALL have parameter MAX_DATA, default 5: max data-contents words per frame.
REQ-003 SHALL have parameter MAX_WORDS, default 15: max words per frame, END included.
REQ-004 SHALL have parameters START_CODE=1, END_CODE=2, INFO_CODE=3, DATA_CODE=4 (W bits): option type codes.
REQ-005 SHALL use one clock and an asynchronous, active-low reset, as listed first and second below.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 in_valid  input  1  in_word is valid.
REQ-009 in_word  input  W  option stream word.
REQ-010 in_ready  output  1  parser accepts in_word this cycle.
REQ-011 out_valid  output  1  parsed frame result is available.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 has_start, has_info, has_data, has_end, is_empty, has_error  output  1 each  frame flags.
REQ-014 info_pos, data_pos, end_pos  output  32 each  word index of that option within the frame, starting at 0.
REQ-015 info_contents, data_len  output  W each  info payload; data length word.
REQ-016 data_contents  output  MAX_DATA*W  data payload; word k at bits [k*W +: W].
REQ-017 word_count  output  32  words consumed in the frame.

Function
REQ-018 A word SHALL be consumed only in a cycle where in_valid and in_ready are both 1.
REQ-019 in_ready SHALL be 1 in every state except DONE.
REQ-020 The FSM SHALL have the states READY, STARTPARSING, INFOPARSING, DATAPARSING, ENDPARSING and DONE.
REQ-021 READY: a consumed START_CODE SHALL set has_start, set word_count=1, and go to STARTPARSING.
REQ-022 READY: any other consumed word SHALL set has_error and go to DONE.
REQ-023 STARTPARSING: INFO_CODE SHALL record info_pos, set has_info, and go to INFOPARSING.
REQ-024 STARTPARSING: DATA_CODE SHALL record data_pos, set has_data, and go to DATAPARSING.
REQ-025 STARTPARSING: END_CODE SHALL record end_pos, set has_end, set is_empty if neither has_info nor has_data is set, and go to ENDPARSING.
REQ-026 STARTPARSING: START_CODE, any unknown code, or a second INFO_CODE or DATA_CODE SHALL set has_error and go to DONE.
REQ-027 INFOPARSING: the next consumed word SHALL be stored in info_contents, and the FSM SHALL return to STARTPARSING.
REQ-028 DATAPARSING: the first consumed word SHALL be stored in data_len.
REQ-029 DATAPARSING: if data_len is 0 the FSM SHALL return to STARTPARSING; if data_len > MAX_DATA it SHALL set has_error and go to DONE.
REQ-030 DATAPARSING: otherwise the next data_len words SHALL be stored in data_contents[0..data_len-1], then the FSM SHALL return to STARTPARSING.
REQ-031 ENDPARSING SHALL assert out_valid and go to DONE in the cycle after END is consumed (one-cycle latency).
REQ-032 The error path SHALL go to DONE directly, with out_valid asserted in the following cycle.
REQ-033 Every consumed word SHALL increment word_count.
REQ-034 If word_count reaches MAX_WORDS without END consumed, has_error SHALL be set and the FSM SHALL go to DONE; a word at index MAX_WORDS-1 is therefore valid only if it is END_CODE.
REQ-035 DONE SHALL hold out_valid and every result output stable until out_ready=1.
REQ-036 On the out_valid&out_ready cycle, the FSM SHALL clear all flags, positions, contents and word_count to 0 and go to READY.
REQ-037 in_ready SHALL be 0 in DONE, including during the accept cycle, so no word is lost or consumed then.
REQ-038 Unused data_contents slots SHALL read 0.
REQ-039 in_valid=0 SHALL stall the FSM in any state with all outputs unchanged.
REQ-040 Position counting SHALL wrap modulo 2^32; this is unreachable while MAX_WORDS < 2^32.

Reset
REQ-041 While rst_n=0, all outputs SHALL be 0 and the FSM SHALL be in READY, regardless of clk.
REQ-042 Reset asserted mid-frame or in DONE SHALL discard the partial result with no out_valid.
REQ-043 The first word accepted after rst_n deasserts SHALL be treated as index 0 of a new frame.

Verification
REQ-044 Stream [1,3,0xAA,4,2,0x11,0x22,2] -> out_valid with has_start/has_info/has_data/has_end=1, info_pos=1, info_contents=0xAA, data_pos=3, data_len=2, data_contents[0]=0x11, data_contents[1]=0x22, end_pos=7, word_count=8, has_error=0.
REQ-045 Stream [1,2] -> is_empty=1, has_end=1, end_pos=1, word_count=2, other flags 0.
REQ-046 Stream [1,4,6] with MAX_DATA=5 -> has_error=1, has_end=0, out_valid 1 cycle after the length word is consumed.
REQ-047 Stream [1,3,5,3] -> has_error=1 on the second INFO; [5] as the first word -> has_error=1, has_start=0.
REQ-048 15 words after START with no END -> has_error=1 on the 15th word; with out_ready held 0 for 10 cycles, outputs stable, in_ready=0, out_valid=1; when out_ready=1, all outputs 0 next cycle.
REQ-049 rst_n pulsed low after [1,3] -> all outputs 0 immediately; then [1,2] -> normal empty frame with end_pos=1.

Source files
------------

// File: rtl/options_parser_stream.sv
`default_nettype none
// ============================================================================
// Module : options_parser_stream
// Brief  : Parses a START/INFO/DATA/END option-word stream into one result record.
// Rev    : 1.0
// ============================================================================
module options_parser_stream #(
    parameter int           W          = 32,
    parameter int           MAX_DATA   = 5,
    parameter int           MAX_WORDS  = 15,
    parameter logic [W-1:0] START_CODE = W'(1),
    parameter logic [W-1:0] END_CODE   = W'(2),
    parameter logic [W-1:0] INFO_CODE  = W'(3),
    parameter logic [W-1:0] DATA_CODE  = W'(4)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [W-1:0]          in_word,
    output logic                  in_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  has_start,
    output logic                  has_info,
    output logic                  has_data,
    output logic                  has_end,
    output logic                  is_empty,
    output logic                  has_error,
    output logic [31:0]           info_pos,
    output logic [31:0]           data_pos,
    output logic [31:0]           end_pos,
    output logic [W-1:0]          info_contents,
    output logic [W-1:0]          data_len,
    output logic [MAX_DATA*W-1:0] data_contents,
    output logic [31:0]           word_count
);

    localparam logic [W-1:0] c_max_data  = W'(MAX_DATA);
    localparam logic [31:0]  c_max_words = 32'(MAX_WORDS);

    typedef enum logic [2:0] {
        ST_READY, ST_STARTPARSING, ST_INFOPARSING, ST_DATAPARSING, ST_ENDPARSING, ST_DONE
    } state_t;

    state_t                r_state, w_state_nxt;
    logic                  r_has_start, r_has_info, r_has_data, r_has_end, r_is_empty, r_has_error;
    logic                  w_has_start_nxt, w_has_info_nxt, w_has_data_nxt, w_has_end_nxt;
    logic                  w_is_empty_nxt, w_has_error_nxt;
    logic [31:0]           r_info_pos, r_data_pos, r_end_pos, r_word_count;
    logic [31:0]           w_info_pos_nxt, w_data_pos_nxt, w_end_pos_nxt, w_word_count_nxt;
    logic [W-1:0]          r_info_contents, r_data_len, w_info_contents_nxt, w_data_len_nxt;
    logic [MAX_DATA*W-1:0] r_data_contents, w_data_contents_nxt;
    logic [W-1:0]          r_data_idx, w_data_idx_nxt;
    logic                  r_len_seen, w_len_seen_nxt;
    logic                  w_accept;
    logic [31:0]           w_cnt_inc;

    assign in_ready  = rst_n && (r_state != ST_DONE);
    assign out_valid = (r_state == ST_DONE);
    assign w_accept  = in_valid && in_ready;
    assign w_cnt_inc = r_word_count + 32'd1;

    always_comb begin
        w_state_nxt         = r_state;
        w_has_start_nxt     = r_has_start;
        w_has_info_nxt      = r_has_info;
        w_has_data_nxt      = r_has_data;
        w_has_end_nxt       = r_has_end;
        w_is_empty_nxt      = r_is_empty;
        w_has_error_nxt     = r_has_error;
        w_info_pos_nxt      = r_info_pos;
        w_data_pos_nxt      = r_data_pos;
        w_end_pos_nxt       = r_end_pos;
        w_word_count_nxt    = r_word_count;
        w_info_contents_nxt = r_info_contents;
        w_data_len_nxt      = r_data_len;
        w_data_contents_nxt = r_data_contents;
        w_data_idx_nxt      = r_data_idx;
        w_len_seen_nxt      = r_len_seen;

        if (w_accept) begin
            w_word_count_nxt = w_cnt_inc;
        end

        case (r_state)
            ST_READY: begin
                if (w_accept) begin
                    if (in_word == START_CODE) begin
                        w_has_start_nxt = 1'b1;
                        w_state_nxt     = ST_STARTPARSING;
                    end else begin
                        w_has_error_nxt = 1'b1;
                        w_state_nxt     = ST_DONE;
                    end
                end
            end
            ST_STARTPARSING: begin
                if (w_accept) begin
                    if (in_word == INFO_CODE && !r_has_info) begin
                        w_has_info_nxt = 1'b1;
                        w_info_pos_nxt = r_word_count;
                        w_state_nxt    = ST_INFOPARSING;
                    end else if (in_word == DATA_CODE && !r_has_data) begin
                        w_has_data_nxt = 1'b1;
                        w_data_pos_nxt = r_word_count;
                        w_state_nxt    = ST_DATAPARSING;
                    end else if (in_word == END_CODE) begin
                        w_has_end_nxt  = 1'b1;
                        w_end_pos_nxt  = r_word_count;
                        w_is_empty_nxt = !r_has_info && !r_has_data;
                        w_state_nxt    = ST_ENDPARSING;
                    end else begin
                        w_has_error_nxt = 1'b1;
                        w_state_nxt     = ST_DONE;
                    end
                end
            end
            ST_INFOPARSING: begin
                if (w_accept) begin
                    w_info_contents_nxt = in_word;
                    w_state_nxt         = ST_STARTPARSING;
                end
            end
            ST_DATAPARSING: begin
                if (w_accept) begin
                    // First word after DATA_CODE is the length; payload words follow.
                    if (!r_len_seen) begin
                        w_data_len_nxt = in_word;
                        if (in_word == '0) begin
                            w_state_nxt = ST_STARTPARSING;
                        end else if (in_word > c_max_data) begin
                            w_has_error_nxt = 1'b1;
                            w_state_nxt     = ST_DONE;
                        end else begin
                            w_len_seen_nxt = 1'b1;
                            w_data_idx_nxt = '0;
                        end
                    end else begin
                        for (int k = 0; k < MAX_DATA; k++) begin
                            if (r_data_idx == W'(k)) begin
                                w_data_contents_nxt[k*W +: W] = in_word;
                            end
                        end
                        w_data_idx_nxt = r_data_idx + W'(1);
                        if (w_data_idx_nxt == r_data_len) begin
                            w_len_seen_nxt = 1'b0;
                            w_state_nxt    = ST_STARTPARSING;
                        end
                    end
                end
            end
            ST_ENDPARSING: begin
                w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_state_nxt         = ST_READY;
                    w_has_start_nxt     = 1'b0;
                    w_has_info_nxt      = 1'b0;
                    w_has_data_nxt      = 1'b0;
                    w_has_end_nxt       = 1'b0;
                    w_is_empty_nxt      = 1'b0;
                    w_has_error_nxt     = 1'b0;
                    w_info_pos_nxt      = '0;
                    w_data_pos_nxt      = '0;
                    w_end_pos_nxt       = '0;
                    w_word_count_nxt    = '0;
                    w_info_contents_nxt = '0;
                    w_data_len_nxt      = '0;
                    w_data_contents_nxt = '0;
                    w_data_idx_nxt      = '0;
                    w_len_seen_nxt      = 1'b0;
                end
            end
            default: begin
                w_state_nxt = ST_READY;
            end
        endcase

        // The last allowed word slot may only hold END; anything else overflows the frame.
        if (w_accept && w_cnt_inc == c_max_words &&
            w_state_nxt != ST_ENDPARSING && w_state_nxt != ST_DONE) begin
            w_has_error_nxt = 1'b1;
            w_state_nxt     = ST_DONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= ST_READY;
            r_has_start     <= 1'b0;
            r_has_info      <= 1'b0;
            r_has_data      <= 1'b0;
            r_has_end       <= 1'b0;
            r_is_empty      <= 1'b0;
            r_has_error     <= 1'b0;
            r_info_pos      <= '0;
            r_data_pos      <= '0;
            r_end_pos       <= '0;
            r_word_count    <= '0;
            r_info_contents <= '0;
            r_data_len      <= '0;
            r_data_contents <= '0;
            r_data_idx      <= '0;
            r_len_seen      <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_has_start     <= w_has_start_nxt;
            r_has_info      <= w_has_info_nxt;
            r_has_data      <= w_has_data_nxt;
            r_has_end       <= w_has_end_nxt;
            r_is_empty      <= w_is_empty_nxt;
            r_has_error     <= w_has_error_nxt;
            r_info_pos      <= w_info_pos_nxt;
            r_data_pos      <= w_data_pos_nxt;
            r_end_pos       <= w_end_pos_nxt;
            r_word_count    <= w_word_count_nxt;
            r_info_contents <= w_info_contents_nxt;
            r_data_len      <= w_data_len_nxt;
            r_data_contents <= w_data_contents_nxt;
            r_data_idx      <= w_data_idx_nxt;
            r_len_seen      <= w_len_seen_nxt;
        end
    end

    assign has_start     = r_has_start;
    assign has_info      = r_has_info;
    assign has_data      = r_has_data;
    assign has_end       = r_has_end;
    assign is_empty      = r_is_empty;
    assign has_error     = r_has_error;
    assign info_pos      = r_info_pos;
    assign data_pos      = r_data_pos;
    assign end_pos       = r_end_pos;
    assign info_contents = r_info_contents;
    assign data_len      = r_data_len;
    assign data_contents = r_data_contents;
    assign word_count    = r_word_count;

endmodule
`default_nettype wire

// File: tb/tb_options_parser_stream.sv
`default_nettype none
// ============================================================================
// Module : tb_options_parser_stream
// Brief  : Scoreboard bench for options_parser_stream with an index-walking frame model.
// Rev    : 1.0
// ============================================================================
module tb_options_parser_stream;

    localparam int W  = 32;
    localparam int MD = 5;
    localparam int MW = 8;

    typedef struct packed {
        logic            hs, hi, hd, he, ie, herr;
        logic [31:0]     ip, dp, ep;
        logic [W-1:0]    ic, dl;
        logic [MD*W-1:0] dc;
        logic [31:0]     wc;
    } res_t;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                in_valid = 1'b0;
    logic [W-1:0]        in_word = '0;
    logic                in_ready, out_valid;
    logic                out_ready = 1'b0;
    logic                has_start, has_info, has_data, has_end, is_empty, has_error;
    logic [31:0]         info_pos, data_pos, end_pos, word_count;
    logic [W-1:0]        info_contents, data_len;
    logic [MD*W-1:0]     data_contents;

    int                  checks = 0;
    int                  fails = 0;
    int                  frames_done = 0;
    bit                  hold_low = 1'b0;
    bit                  accepted_prev = 1'b0;
    res_t                q_exp[$];
    res_t                mon_act;
    logic [W-1:0]        frame[$];

    options_parser_stream #(.W(W), .MAX_DATA(MD), .MAX_WORDS(MW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_word(in_word),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .has_start(has_start), .has_info(has_info), .has_data(has_data),
        .has_end(has_end), .is_empty(is_empty), .has_error(has_error),
        .info_pos(info_pos), .data_pos(data_pos), .end_pos(end_pos),
        .info_contents(info_contents), .data_len(data_len),
        .data_contents(data_contents), .word_count(word_count)
    );

    always #5 clk = ~clk;

    function automatic res_t actual();
        res_t a;
        a = '{has_start, has_info, has_data, has_end, is_empty, has_error,
              info_pos, data_pos, end_pos, info_contents, data_len, data_contents, word_count};
        return a;
    endfunction

    // Walks the frame by option: code, then its payload; n = words the parser should consume.
    function automatic void model(input logic [W-1:0] f[$], output res_t e, output int n);
        int i;
        logic [W-1:0] code, len;
        e = '0;
        if (f[0] != W'(1)) begin
            e.herr = 1'b1; e.wc = 1; n = 1;
            return;
        end
        e.hs = 1'b1;
        i = 1;
        forever begin
            code = f[i];
            i++;
            if (code == W'(2)) begin
                e.he = 1'b1; e.ep = i - 1; e.ie = !e.hi && !e.hd;
                break;
            end else if (code == W'(3) && !e.hi) begin
                e.hi = 1'b1; e.ip = i - 1;
            end else if (code == W'(4) && !e.hd) begin
                e.hd = 1'b1; e.dp = i - 1;
            end else begin
                e.herr = 1'b1;
                break;
            end
            if (i == MW) begin e.herr = 1'b1; break; end
            if (code == W'(3)) begin
                e.ic = f[i];
                i++;
            end else begin
                len = f[i];
                i++;
                e.dl = len;
                if (len > W'(MD)) begin e.herr = 1'b1; break; end
                for (int k = 0; k < int'(len) && i < MW; k++) begin
                    e.dc[k*W +: W] = f[i];
                    i++;
                end
            end
            if (i == MW) begin e.herr = 1'b1; break; end
        end
        e.wc = i;
        n = i;
    endfunction

    task automatic pad_frame();
        while (frame.size() < MW + 2) frame.push_back(W'($urandom_range(0, 6)));
    endtask

    task automatic gen_frame();
        int len;
        frame = {};
        if ($urandom_range(0, 9) == 0) frame.push_back(W'($urandom_range(0, 6)));
        else frame.push_back(W'(1));
        for (int s = 0; s < 3; s++) begin
            case ($urandom_range(0, 5))
                0, 1: begin frame.push_back(W'(3)); frame.push_back(W'($urandom)); end
                2, 3: begin
                    len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(6, 9)) : int'($urandom_range(0, 5));
                    frame.push_back(W'(4));
                    frame.push_back(W'(len));
                    for (int k = 0; k < len; k++) frame.push_back(W'($urandom));
                end
                4: frame.push_back(W'($urandom_range(0, 6)));
                default: ;
            endcase
            if ($urandom_range(0, 2) == 0) break;
        end
        frame.push_back(W'(2));
        pad_frame();
    endtask

    task automatic drive_word(input logic [W-1:0] wd, output bit ok);
        int tmo;
        if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            in_word  = W'($urandom);
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        in_valid = 1'b1;
        in_word  = wd;
        tmo = 0;
        while (!in_ready && tmo < 20) begin @(negedge clk); tmo++; end
        ok = in_ready;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_words();
        res_t e;
        int   n;
        bit   ok;
        model(frame, e, n);
        q_exp.push_back(e);
        for (int i = 0; i < n; i++) begin
            drive_word(frame[i], ok);
            checks++;
            if (!ok) begin
                fails++;
                $display("FAIL in_ready_mid_frame word=%0d act=0 exp=1", i);
            end
        end
        checks++;
        if (out_valid !== e.herr) begin
            fails++;
            $display("FAIL out_valid_latency1 act=%0b exp=%0b", out_valid, e.herr);
        end
        if (!e.herr) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1) begin
                fails++;
                $display("FAIL out_valid_latency2 act=%0b exp=1", out_valid);
            end
        end
    endtask

    task automatic wait_done(input int target);
        int tmo = 0;
        while (frames_done < target && tmo < 200) begin @(negedge clk); tmo++; end
        checks++;
        if (frames_done < target) begin
            fails++;
            $display("FAIL frame_timeout act_done=%0d exp_done=%0d", frames_done, target);
        end
    endtask

    task automatic send_frame();
        int target;
        target = frames_done + 1;
        send_words();
        wait_done(target);
    endtask

    task automatic check_all_zero(input string nm);
        checks++;
        if (actual() !== '0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL %s act=%h ov=%0b ir=%0b exp=0", nm, actual(), out_valid, in_ready);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            out_ready     = 1'b0;
            accepted_prev = 1'b0;
        end else begin
            mon_act = actual();
            if (accepted_prev) begin
                checks++;
                if (mon_act !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
                    fails++;
                    $display("FAIL cleared_after_accept act=%h ov=%0b ir=%0b exp=0/0/1",
                             mon_act, out_valid, in_ready);
                end
            end
            accepted_prev = 1'b0;
            if (out_valid) begin
                checks++;
                if (q_exp.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_out_valid act=%h exp=none", mon_act);
                end else if (mon_act !== q_exp[0] || in_ready !== 1'b0) begin
                    fails++;
                    $display("FAIL frame_result act=%h ir=%0b exp=%h ir=0", mon_act, in_ready, q_exp[0]);
                end
            end
            out_ready = hold_low ? 1'b0 : ($urandom_range(0, 2) != 0);
            if (out_valid && out_ready) begin
                if (q_exp.size() > 0) void'(q_exp.pop_front());
                frames_done++;
                accepted_prev = 1'b1;
            end
        end
    end

    initial begin
        bit ok;
        int target;
        repeat (2) @(negedge clk);
        check_all_zero("reset_state");
        rst_n = 1'b1;
        @(negedge clk);

        frame = {W'(1), W'(3), W'(32'hAA), W'(4), W'(2), W'(32'h11), W'(32'h22), W'(2)};
        pad_frame(); send_frame();
        frame = {W'(1), W'(2)};
        pad_frame(); send_frame();
        frame = {W'(1), W'(4), W'(6)};
        pad_frame(); send_frame();
        frame = {W'(1), W'(3), W'(5), W'(3)};
        pad_frame(); send_frame();
        frame = {W'(5)};
        pad_frame(); send_frame();

        // Overflow frame held in DONE with the consumer stalled.
        hold_low = 1'b1;
        target   = frames_done + 1;
        frame = {W'(1), W'(4), W'(5), W'(32'hA1), W'(32'hB2), W'(32'hC3), W'(32'hD4), W'(32'hE5)};
        pad_frame();
        send_words();
        repeat (10) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                fails++;
                $display("FAIL done_hold act_ir=%0b act_ov=%0b exp_ir=0 exp_ov=1", in_ready, out_valid);
            end
        end
        hold_low = 1'b0;
        wait_done(target);

        // Reset in the middle of a frame discards it.
        drive_word(W'(1), ok);
        drive_word(W'(3), ok);
        #2 rst_n = 1'b0;
        #1 check_all_zero("reset_mid_frame");
        @(negedge clk);
        rst_n = 1'b1;
        frame = {W'(1), W'(2)};
        pad_frame(); send_frame();

        for (int t = 0; t < 150; t++) begin
            gen_frame();
            send_frame();
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog_timeout act=running exp=finished");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
